// File: rtl/xor_stream_decoder.sv
// Byte-serial XOR keystream decoder: each accepted byte is XORed with an
// 8-bit Galois LFSR that then advances; one registered output stage.
module xor_stream_decoder #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] SEED  = 8'hA5,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [7:0]       count
);

  logic [WIDTH-1:0] lfsr_reg, lfsr_next, lfsr_step;
  logic [WIDTH-1:0] data_reg, data_next;
  logic             valid_reg, valid_next;
  logic [7:0]       count_reg, count_next;
  logic [WIDTH-1:0] seed_safe;
  logic             accept;
  logic             drain;

  // The output stage can take a new byte when empty or being drained this cycle.
  assign in_ready = !rst && (!valid_reg || out_ready) && !seed_load;
  assign accept   = in_valid && in_ready;
  assign drain    = valid_reg && out_ready;

  // A zero seed would lock the LFSR, so it is replaced by the default seed.
  assign seed_safe = (seed == '0) ? SEED : seed;

  // Galois step: shift right, fold the dropped LSB back in through the taps.
  generate
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_step
      assign lfsr_step[gi] = lfsr_reg[gi+1] ^ (lfsr_reg[0] & TAPS[gi]);
    end
  endgenerate
  assign lfsr_step[WIDTH-1] = lfsr_reg[0] & TAPS[WIDTH-1];

  always_comb begin
    lfsr_next  = lfsr_reg;
    data_next  = data_reg;
    valid_next = valid_reg;
    count_next = count_reg;

    if (seed_load) begin
      lfsr_next  = seed_safe;
      count_next = 8'h00;
    end else if (accept) begin
      lfsr_next  = lfsr_step;
      count_next = count_reg + 8'd1;
    end

    if (accept) begin
      data_next  = in_data ^ lfsr_reg;
      valid_next = 1'b1;
    end else if (drain) begin
      valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_reg  <= SEED;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      count_reg <= 8'h00;
    end else begin
      lfsr_reg  <= lfsr_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      count_reg <= count_next;
    end
  end

  assign out_valid = valid_reg;
  assign out_data  = data_reg;
  assign count     = count_reg;

endmodule

// File: doc/xor_stream_decoder.md
Name: xor_stream_decoder

Overview:
- Byte-serial XOR keystream decoder for the 8-bit ALU datapath. It is the receive/decode end of the XOR-scramble path.
- Each accepted byte is XORed with the current state of an 8-bit Galois LFSR. The LFSR then advances.
- XOR is self-inverse, so running the same seed on the encode side recovers the plaintext.
- Valid/ready handshake on both sides, with one registered output stage.

Parameters:
- WIDTH, 8, data and LFSR width; only 8 is supported.
- SEED, 8'hA5, LFSR value after reset, and the substitute when a zero seed is loaded.
- TAPS, 8'hB8, Galois feedback mask (x^8+x^6+x^5+x^4+1).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- seed_load  input  1  load seed into LFSR and clear count
- seed  input  8  new LFSR seed
- in_valid  input  1  in_data is valid
- in_ready  output  1  decoder can accept a byte this cycle
- in_data  input  8  scrambled byte
- out_valid  output  1  out_data holds a decoded byte
- out_ready  input  1  downstream accepts out_data
- out_data  output  8  decoded byte
- count  output  8  bytes accepted since reset or last seed_load

Behaviour:
- Reset (asynchronous, rst=1), all values in force while rst is high:
  - lfsr=SEED, out_valid=0, out_data=8'h00, count=8'h00.
  - in_ready=0 while rst=1.
  - Reset mid-transfer discards any held output byte.
- in_ready is combinational: (!out_valid || out_ready) && !seed_load.
- Accept when in_valid && in_ready at the clock edge:
  - out_data <= in_data ^ lfsr.
  - out_valid <= 1.
  - lfsr <= (lfsr>>1) ^ (lfsr[0] ? TAPS : 8'h00).
  - count <= count+1, wrapping 8'hFF -> 8'h00.
- Latency: one cycle from accept to out_valid.
- Throughput: one byte per cycle when out_ready is held high.
- Output handshake:
  - If out_valid && out_ready and there is no accept, out_valid <= 0 and out_data holds its value.
  - If out_valid && !out_ready, out_data and out_valid are held stable, and in_ready=0.
  - Simultaneous drain and accept: the new byte replaces the old one and out_valid stays 1.
- seed_load=1:
  - lfsr <= (seed==0) ? SEED : seed, so the LFSR can never lock up at zero.
  - count <= 0.
  - No byte is accepted that cycle, because in_ready is forced to 0.
  - An already held out_data/out_valid is unaffected and still drains normally.
  - seed_load has priority over LFSR advance.
- The LFSR advances only on accept. It never advances on idle cycles or stall cycles.
- in_valid while in_ready=0 has no effect. The source must hold in_data until it is accepted.
- The first keystream bytes from SEED=8'hA5 are 8'hA5, 8'hEA, 8'h75, 8'h82.

Test Plan:
- Keystream check: after reset, out_ready=1, send 8'h00 x4 on consecutive cycles → out_data 8'hA5, 8'hEA, 8'h75, 8'h82 on the following cycles; count=4.
- Decode check: after reset, send 8'hFF then 8'h0F → out_data 8'h5A then 8'hE5.
- Back-pressure: hold out_ready=0 after the first accept → in_ready=0, out_data stays 8'hA5, lfsr stays 8'hEA. Release out_ready → the next byte 8'h00 decodes to 8'hEA.
- Seed load:
  - Pulse seed_load with seed=8'h01 → in_ready=0 that cycle, count=0. The next byte 8'h00 decodes to 8'h01, and the following 8'h00 decodes to 8'hB8.
  - seed=8'h00 → the stream restarts at 8'hA5.
- Count wrap: accept 256 bytes → count returns to 8'h00, and out_valid behaviour is unchanged.
- Async reset mid-stream: assert rst between clock edges while out_valid=1 → out_valid=0, count=0, in_ready=0 immediately. After release, the next byte 8'h00 decodes to 8'hA5.
